// File: rtl/ahb_pkg.sv
// Shared encodings for the AHB split memory slave.
//   - HTRANS_* : transfer type codes driven by the master.
//   - HRESP_*  : slave response codes.
//   - resp_state_e  : two-cycle response sequencer states.
//   - split_state_e : split read engine states.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  typedef enum logic [1:0] {
    R_OKAY  = 2'b00,
    R_RESP1 = 2'b01,
    R_RESP2 = 2'b10
  } resp_state_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_WAIT  = 2'b01,
    S_READY = 2'b10
  } split_state_e;

endpackage

// File: rtl/ahb_split_ctrl.sv
// Split read engine: owns the one outstanding split read.
//   hclk, hresetn   : clock, asynchronous active-low reset
//   rd_req          : an in-range read was accepted this cycle
//   rd_idx          : word index of that read
//   wr_en/wr_idx/wr_data : memory write completing this cycle
//   fetch_data      : memory word at lat_idx (write-forwarded by the caller)
//   split_resp      : answer the current read with SPLIT (engine takes it)
//   retry_resp      : answer the current read with RETRY (engine busy)
//   hit_resp        : current read is the re-issue; return hit_data, OKAY
//   hit_data        : buffered word, coherent with a same-cycle write
//   lat_idx         : latched word index of the outstanding split
//   split_in        : 1-cycle pulse to the arbiter, data is buffered
//   valid_aft_split_in : 1-cycle pulse in the data phase of the re-issue
//   state_o         : engine state for observation
module ahb_split_ctrl
  import ahb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 5,
  parameter int SPLIT_LAT = 8
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              rd_req,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] fetch_data,
  output logic              split_resp,
  output logic              retry_resp,
  output logic              hit_resp,
  output logic [DATA_W-1:0] hit_data,
  output logic [IDX_W-1:0]  lat_idx,
  output logic              split_in,
  output logic              valid_aft_split_in,
  output split_state_e      state_o
);

  localparam int CNT_W = (SPLIT_LAT > 1) ? $clog2(SPLIT_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SPLIT_LAT > 0) ? SPLIT_LAT - 1 : 0);

  split_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              valid_q, valid_d;
  logic              wr_match;

  assign wr_match = wr_en && (wr_idx == idx_q);
  // A write landing on the latched word in the same cycle as the re-issue
  // must win over the stale buffer.
  assign hit_data = wr_match ? wr_data : buf_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    valid_d    = 1'b0;
    split_resp = 1'b0;
    retry_resp = 1'b0;
    hit_resp   = 1'b0;
    split_in   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          split_resp = 1'b1;
          idx_d      = rd_idx;
          cnt_d      = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // The split master should not be re-granted yet, so any read here
        // (including an early re-issue) is turned away.
        if (rd_req) retry_resp = 1'b1;
        if (cnt_q == CNT_LAST) begin
          buf_d    = fetch_data;
          split_in = 1'b1;
          state_d  = S_READY;
        end
      end
      S_READY: begin
        if (wr_match) buf_d = wr_data;
        if (rd_req) begin
          if (rd_idx == idx_q) begin
            hit_resp = 1'b1;
            valid_d  = 1'b1;
            state_d  = S_IDLE;
          end else begin
            retry_resp = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
    end
  end

  assign lat_idx            = idx_q;
  assign valid_aft_split_in = valid_q;
  assign state_o            = state_q;

endmodule

// File: rtl/ahb_split_mem_slave.sv
// AHB slave with a single-port word memory, a read-only low region and
// optional SPLIT-deferred reads.
//   hclk, hresetn : clock, asynchronous active-low reset
//   hsel, haddr, htrans, hwrite : address phase from decoder/master
//   hwdata        : write data, valid in the data phase
//   hready        : bus ready; the address phase is taken only when high
//   hready_out    : slave ready (low only in the first cycle of a non-OKAY)
//   hresp         : OKAY/ERROR/RETRY/SPLIT
//   hrdata        : read data, holds its last value otherwise
//   error         : pulse in the first cycle of every ERROR response
//   split_in      : pulse to the arbiter when split data is buffered
//   valid_aft_split_in : pulse when buffered split data is returned
//
// Handshake: a transfer is taken when hsel & hready & htrans is NONSEQ/SEQ;
// its data phase completes in the first cycle with hready_out high. OKAY is
// zero-wait; every other response is hready_out=0 then hready_out=1 with the
// same hresp code on both cycles.
module ahb_split_mem_slave
  import ahb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH      = 32,
  parameter int PROT_WORDS = 5,
  parameter int INIT_WORDS = 5,
  parameter int SPLIT_LAT  = 8
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  output logic              hready_out,
  output logic [1:0]        hresp,
  output logic [DATA_W-1:0] hrdata,
  output logic              error,
  output logic              split_in,
  output logic              valid_aft_split_in
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0]  PROT_LIM = (IDX_W+1)'(PROT_WORDS);
  // One extra bit so 4*DEPTH never truncates against the address width.
  localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W+1)'(4 * DEPTH);
  localparam bit SPLIT_EN = (SPLIT_LAT > 0);

  resp_state_e       rstate_q, rstate_d;
  logic [1:0]        rcode_q, rcode_d;
  logic              wr_pend_q, wr_pend_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              is_xfer;
  logic              accept;
  logic              in_range;
  logic              prot;
  logic              rd_req;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_fwd;
  logic [DATA_W-1:0] fetch_data;
  logic [1:0]        acc_code;

  logic              split_resp, retry_resp, hit_resp;
  logic [DATA_W-1:0] hit_data;
  logic [IDX_W-1:0]  lat_idx;
  split_state_e      split_state;
  logic [1:0]        dbg_unused;

  always_comb begin
    is_xfer = 1'b0;
    unique case (htrans)
      HTRANS_IDLE, HTRANS_BUSY: is_xfer = 1'b0;
      HTRANS_NONSEQ, HTRANS_SEQ: is_xfer = 1'b1;
      default: is_xfer = 1'b0;
    endcase
  end

  // The bus already holds hready low during R_RESP1; the extra term keeps the
  // sequencer safe if hready is ever sourced from elsewhere.
  assign accept   = hsel & hready & is_xfer & (rstate_q != R_RESP1);
  assign idx      = haddr[2 +: IDX_W];
  assign in_range = {1'b0, haddr} < ADDR_LIM;
  assign prot     = {1'b0, idx} < PROT_LIM;
  assign rd_req   = accept & ~hwrite & in_range & SPLIT_EN;

  // A read taken during the data phase of a write to the same word sees the
  // new data, since the memory only updates at the end of that cycle.
  assign rd_fwd     = (wr_pend_q && (wr_idx_q == idx))     ? hwdata : mem_q[idx];
  assign fetch_data = (wr_pend_q && (wr_idx_q == lat_idx)) ? hwdata : mem_q[lat_idx];

  ahb_split_ctrl #(
    .DATA_W    (DATA_W),
    .IDX_W     (IDX_W),
    .SPLIT_LAT (SPLIT_LAT)
  ) u_split_ctrl (
    .hclk               (hclk),
    .hresetn            (hresetn),
    .rd_req             (rd_req),
    .rd_idx             (idx),
    .wr_en              (wr_pend_q),
    .wr_idx             (wr_idx_q),
    .wr_data            (hwdata),
    .fetch_data         (fetch_data),
    .split_resp         (split_resp),
    .retry_resp         (retry_resp),
    .hit_resp           (hit_resp),
    .hit_data           (hit_data),
    .lat_idx            (lat_idx),
    .split_in           (split_in),
    .valid_aft_split_in (valid_aft_split_in),
    .state_o            (split_state)
  );

  // Engine state is brought out for observation only.
  assign dbg_unused = split_state;

  always_comb begin
    rstate_d  = rstate_q;
    rcode_d   = rcode_q;
    wr_pend_d = 1'b0;
    wr_idx_d  = wr_idx_q;
    hrdata_d  = hrdata_q;
    acc_code  = HRESP_OKAY;
    mem_d     = mem_q;
    if (wr_pend_q) mem_d[wr_idx_q] = hwdata;

    if (accept) begin
      if (hwrite) begin
        if (!in_range || prot) begin
          acc_code = HRESP_ERROR;
        end else begin
          wr_pend_d = 1'b1;
          wr_idx_d  = idx;
        end
      end else if (!in_range) begin
        acc_code = HRESP_ERROR;
      end else if (!SPLIT_EN) begin
        hrdata_d = rd_fwd;
      end else if (split_resp) begin
        acc_code = HRESP_SPLIT;
      end else if (retry_resp) begin
        acc_code = HRESP_RETRY;
      end else if (hit_resp) begin
        hrdata_d = hit_data;
      end
    end

    unique case (rstate_q)
      R_RESP1: rstate_d = R_RESP2;
      default: begin
        if (acc_code != HRESP_OKAY) begin
          rstate_d = R_RESP1;
          rcode_d  = acc_code;
        end else begin
          rstate_d = R_OKAY;
        end
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      rstate_q  <= R_OKAY;
      rcode_q   <= HRESP_OKAY;
      wr_pend_q <= 1'b0;
      wr_idx_q  <= '0;
      hrdata_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= (i < INIT_WORDS) ? DATA_W'(i + 1) : '0;
      end
    end else begin
      rstate_q  <= rstate_d;
      rcode_q   <= rcode_d;
      wr_pend_q <= wr_pend_d;
      wr_idx_q  <= wr_idx_d;
      hrdata_q  <= hrdata_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign hready_out = (rstate_q != R_RESP1);
  assign hresp      = (rstate_q == R_OKAY) ? HRESP_OKAY : rcode_q;
  assign hrdata     = hrdata_q;
  assign error      = (rstate_q == R_RESP1) && (rcode_q == HRESP_ERROR);

endmodule

// File: tb/tb_ahb_split_mem_slave.sv
// Bench for ahb_split_mem_slave: one instance without SPLIT (LAT=0) and one
// with SPLIT_LAT=8 share the bus; hready is the AND of both slaves' ready.
module tb_ahb_split_mem_slave;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SEQ = 2'b11;
  localparam logic [1:0] OKAY = 2'b00, ERR = 2'b01, RTY = 2'b10, SPL = 2'b11;

  // ---------------- clock / reset ----------------
  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  always #5 hclk = ~hclk;

  int cyc = 0;
  always @(posedge hclk) cyc <= cyc + 1;

  logic        hsel0, hsel8;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready;

  logic        hready_out0, hready_out8;
  logic [1:0]  hresp0, hresp8;
  logic [31:0] hrdata0, hrdata8;
  logic        error0, error8, split_in0, split_in8, vas0, vas8;

  assign hready = hready_out0 & hready_out8;

  ahb_split_mem_slave #(.SPLIT_LAT(0)) u_dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hwdata(hwdata), .hready(hready), .hready_out(hready_out0),
    .hresp(hresp0), .hrdata(hrdata0), .error(error0), .split_in(split_in0),
    .valid_aft_split_in(vas0)
  );

  ahb_split_mem_slave #(.SPLIT_LAT(8)) u_dut8 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel8), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hwdata(hwdata), .hready(hready), .hready_out(hready_out8),
    .hresp(hresp8), .hrdata(hrdata8), .error(error8), .split_in(split_in8),
    .valid_aft_split_in(vas8)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_resp_q[$];
  logic [31:0] exp_data_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int acc_cyc = 0;

  int split0_cnt = 0;
  int split8_cnt = 0;
  int split8_edge = 0;
  int exp_split8 = 0;

  always @(negedge hclk) begin
    if (split_in0) split0_cnt++;
    if (split_in8) begin
      split8_cnt++;
      split8_edge = cyc + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_hready_out0", 32'(hready_out0), 32'd1);
    check("rst_hresp0", 32'(hresp0), 32'(OKAY));
    check("rst_hrdata0", hrdata0, 32'd0);
    check("rst_error0", 32'(error0), 32'd0);
    check("rst_split_in0", 32'(split_in0), 32'd0);
    check("rst_vas0", 32'(vas0), 32'd0);
    check("rst_hready_out8", 32'(hready_out8), 32'd1);
    check("rst_hresp8", 32'(hresp8), 32'(OKAY));
    check("rst_hrdata8", hrdata8, 32'd0);
    check("rst_error8", 32'(error8), 32'd0);
    check("rst_split_in8", 32'(split_in8), 32'd0);
    check("rst_vas8", 32'(vas8), 32'd0);
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after a rising edge.
  task automatic xfer(input bit use8, input logic [1:0] trans, input bit sel, input bit wr,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] er, input logic [31:0] ed, input bit chk_rd,
                      input bit ev);
    logic        rdy, err, va;
    logic [1:0]  rs;
    logic [31:0] rd, r, d;
    hsel0  = sel & ~use8;
    hsel8  = sel & use8;
    htrans = trans;
    hwrite = wr;
    haddr  = addr;
    exp_resp_q.push_back(32'(er));
    exp_data_q.push_back(ed);
    @(posedge hclk); #1;
    acc_cyc = cyc;
    hsel0 = 1'b0; hsel8 = 1'b0; htrans = T_IDLE; hwrite = 1'b0; haddr = '0;
    hwdata = wdata;
    @(negedge hclk);
    r = exp_resp_q.pop_front();
    d = exp_data_q.pop_front();
    rdy = use8 ? hready_out8 : hready_out0;
    rs  = use8 ? hresp8 : hresp0;
    rd  = use8 ? hrdata8 : hrdata0;
    err = use8 ? error8 : error0;
    va  = use8 ? vas8 : vas0;
    if (r == 32'(OKAY)) begin
      check("okay_hready_out", 32'(rdy), 32'd1);
      check("okay_hresp", 32'(rs), 32'(OKAY));
      check("okay_error", 32'(err), 32'd0);
      check("valid_aft_split_in", 32'(va), 32'(ev));
      if (chk_rd) check("hrdata", rd, d);
    end else begin
      check("resp1_hready_out", 32'(rdy), 32'd0);
      check("resp1_hresp", 32'(rs), r);
      check("resp1_error", 32'(err), (r == 32'(ERR)) ? 32'd1 : 32'd0);
      @(posedge hclk);
      @(negedge hclk);
      rdy = use8 ? hready_out8 : hready_out0;
      rs  = use8 ? hresp8 : hresp0;
      err = use8 ? error8 : error0;
      check("resp2_hready_out", 32'(rdy), 32'd1);
      check("resp2_hresp", 32'(rs), r);
      check("resp2_error", 32'(err), 32'd0);
    end
    @(posedge hclk); #1;
    hwdata = '0;
  endtask

  task automatic wait_split(input int acc);
    int n = 0;
    exp_split8++;
    while (split8_cnt < exp_split8 && n < 40) begin
      @(posedge hclk); #1;
      n++;
    end
    check("split_in_seen", 32'(split8_cnt), 32'(exp_split8));
    check("split_in_delay", 32'(split8_edge - acc), 32'd8);
  endtask

  // ---------------- vector table (LAT=0 instance) ----------------
  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  er;
    logic [31:0] ed;
    bit          chk;
  } vec_t;

  vec_t tbl[18];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    tbl[0]  = '{1'b1, T_NS,   1'b0, 32'h08, 32'h0,        OKAY, 32'd3,        1'b1};
    tbl[1]  = '{1'b1, T_NS,   1'b1, 32'h10, 32'hDEADBEEF, ERR,  32'd0,        1'b0};
    tbl[2]  = '{1'b1, T_NS,   1'b0, 32'h10, 32'h0,        OKAY, 32'd5,        1'b1};
    tbl[3]  = '{1'b1, T_NS,   1'b1, 32'h14, 32'h12345678, OKAY, 32'd0,        1'b0};
    tbl[4]  = '{1'b1, T_NS,   1'b0, 32'h14, 32'h0,        OKAY, 32'h12345678, 1'b1};
    tbl[5]  = '{1'b1, T_NS,   1'b0, 32'h80, 32'h0,        ERR,  32'd0,        1'b0};
    tbl[6]  = '{1'b1, T_IDLE, 1'b0, 32'h08, 32'h0,        OKAY, 32'h12345678, 1'b1};
    tbl[7]  = '{1'b0, T_NS,   1'b1, 32'h20, 32'h0000FFFF, OKAY, 32'd0,        1'b0};
    tbl[8]  = '{1'b1, T_NS,   1'b0, 32'h20, 32'h0,        OKAY, 32'd0,        1'b1};
    tbl[9]  = '{1'b1, T_NS,   1'b1, 32'h7C, 32'hCAFEF00D, OKAY, 32'd0,        1'b0};
    tbl[10] = '{1'b1, T_NS,   1'b0, 32'h7C, 32'h0,        OKAY, 32'hCAFEF00D, 1'b1};
    tbl[11] = '{1'b1, T_BUSY, 1'b0, 32'h08, 32'h0,        OKAY, 32'hCAFEF00D, 1'b1};
    tbl[12] = '{1'b1, T_NS,   1'b1, 32'h00, 32'h00000011, ERR,  32'd0,        1'b0};
    tbl[13] = '{1'b1, T_NS,   1'b0, 32'h00, 32'h0,        OKAY, 32'd1,        1'b1};
    tbl[14] = '{1'b1, T_NS,   1'b1, 32'h80000014, 32'h99, ERR,  32'd0,        1'b0};
    tbl[15] = '{1'b1, T_NS,   1'b0, 32'h14, 32'h0,        OKAY, 32'h12345678, 1'b1};
    tbl[16] = '{1'b1, T_SEQ,  1'b0, 32'h04, 32'h0,        OKAY, 32'd2,        1'b1};
    tbl[17] = '{1'b1, T_NS,   1'b1, 32'h84, 32'h1,        ERR,  32'd0,        1'b0};

    hsel0 = 1'b0; hsel8 = 1'b0; haddr = '0; htrans = T_IDLE; hwrite = 1'b0; hwdata = '0;
    hresetn = 1'b0;
    @(negedge hclk);
    @(negedge hclk);
    check_reset_outputs();
    @(posedge hclk); #1;
    hresetn = 1'b1;
    @(posedge hclk); #1;

    for (int i = 0; i < 18; i++) begin
      xfer(1'b0, tbl[i].trans, tbl[i].sel, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
           tbl[i].er, tbl[i].ed, tbl[i].chk, 1'b0);
    end

    // Pipelined write then read of the same word: the read's address phase
    // overlaps the write's data phase.
    hsel0 = 1'b1; htrans = T_NS; hwrite = 1'b1; haddr = 32'h24;
    @(posedge hclk); #1;
    hwrite = 1'b0; hwdata = 32'h0BADF00D;
    @(negedge hclk);
    check("b2b_wr_hready_out", 32'(hready_out0), 32'd1);
    check("b2b_wr_hresp", 32'(hresp0), 32'(OKAY));
    @(posedge hclk); #1;
    hsel0 = 1'b0; htrans = T_IDLE; haddr = '0; hwdata = '0;
    @(negedge hclk);
    check("b2b_rd_hrdata", hrdata0, 32'h0BADF00D);
    @(posedge hclk); #1;

    // Split read round trip.
    xfer(1'b1, T_NS, 1'b1, 1'b1, 32'h18, 32'hA5A5A5A5, OKAY, 32'd0, 1'b0, 1'b0);
    xfer(1'b1, T_NS, 1'b1, 1'b0, 32'h18, 32'h0, SPL, 32'd0, 1'b0, 1'b0);
    acc = acc_cyc;
    wait_split(acc);
    xfer(1'b1, T_NS, 1'b1, 1'b0, 32'h18, 32'h0, OKAY, 32'hA5A5A5A5, 1'b1, 1'b1);

    // Second read while pending is retried; a write during S_WAIT is fetched.
    xfer(1'b1, T_NS, 1'b1, 1'b0, 32'h18, 32'h0, SPL, 32'd0, 1'b0, 1'b0);
    acc = acc_cyc;
    xfer(1'b1, T_NS, 1'b1, 1'b0, 32'h1C, 32'h0, RTY, 32'd0, 1'b0, 1'b0);
    xfer(1'b1, T_NS, 1'b1, 1'b1, 32'h18, 32'h55, OKAY, 32'd0, 1'b0, 1'b0);
    wait_split(acc);
    xfer(1'b1, T_NS, 1'b1, 1'b0, 32'h18, 32'h0, OKAY, 32'h55, 1'b1, 1'b1);

    // Write during S_READY updates the buffer; other-index read is retried.
    xfer(1'b1, T_NS, 1'b1, 1'b0, 32'h18, 32'h0, SPL, 32'd0, 1'b0, 1'b0);
    acc = acc_cyc;
    wait_split(acc);
    xfer(1'b1, T_NS, 1'b1, 1'b1, 32'h18, 32'h77, OKAY, 32'd0, 1'b0, 1'b0);
    xfer(1'b1, T_NS, 1'b1, 1'b0, 32'h20, 32'h0, RTY, 32'd0, 1'b0, 1'b0);
    xfer(1'b1, T_NS, 1'b1, 1'b0, 32'h18, 32'h0, OKAY, 32'h77, 1'b1, 1'b1);

    // Out-of-range read and IDLE on the split instance.
    xfer(1'b1, T_NS, 1'b1, 1'b0, 32'h80, 32'h0, ERR, 32'd0, 1'b0, 1'b0);
    xfer(1'b1, T_IDLE, 1'b1, 1'b0, 32'h18, 32'h0, OKAY, 32'h77, 1'b1, 1'b0);

    // Reset while the engine is in S_WAIT.
    xfer(1'b1, T_NS, 1'b1, 1'b0, 32'h18, 32'h0, SPL, 32'd0, 1'b0, 1'b0);
    @(posedge hclk); #1;
    hresetn = 1'b0;
    @(negedge hclk);
    check_reset_outputs();
    @(posedge hclk);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    repeat (20) @(posedge hclk);
    #1;
    check("no_split_after_reset", 32'(split8_cnt), 32'(exp_split8));

    xfer(1'b0, T_NS, 1'b1, 1'b0, 32'h14, 32'h0, OKAY, 32'd0, 1'b1, 1'b0);
    xfer(1'b0, T_NS, 1'b1, 1'b0, 32'h10, 32'h0, OKAY, 32'd5, 1'b1, 1'b0);
    xfer(1'b0, T_NS, 1'b1, 1'b0, 32'h7C, 32'h0, OKAY, 32'd0, 1'b1, 1'b0);
    xfer(1'b0, T_NS, 1'b1, 1'b0, 32'h24, 32'h0, OKAY, 32'd0, 1'b1, 1'b0);
    xfer(1'b1, T_NS, 1'b1, 1'b0, 32'h18, 32'h0, SPL, 32'd0, 1'b0, 1'b0);
    acc = acc_cyc;
    wait_split(acc);
    xfer(1'b1, T_NS, 1'b1, 1'b0, 32'h18, 32'h0, OKAY, 32'd0, 1'b1, 1'b1);

    // ---------------- report ----------------
    repeat (3) @(posedge hclk);
    #1;
    check("split_in_total", 32'(split8_cnt), 32'(exp_split8));
    check("split_in_lat0", 32'(split0_cnt), 32'd0);
    check("scoreboard_empty", 32'(exp_resp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
